// File: rtl/config_chain_loader_if.sv
// Host/status bundle for the configuration chain loader.
// The host side (master) drives start/abort and the word handshake; the
// loader (slave) drives the serial chain, word_ready and the status outputs.
interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  start;
  logic                  abort;
  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;
  logic                  chain_config_out;
  logic                  chain_config_enable;
  logic                  chain_config_nreset;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  bits_loaded;

  modport master (
    output start, abort, word_data, word_valid,
    input  word_ready, chain_config_out, chain_config_enable,
           chain_config_nreset, busy, done, bits_loaded
  );

  modport slave (
    input  start, abort, word_data, word_valid,
    output word_ready, chain_config_out, chain_config_enable,
           chain_config_nreset, busy, done, bits_loaded
  );
endinterface

// File: rtl/config_chain_loader.sv
// Configuration chain loader: clears the tile config chain, then shifts host
// words into it LSB-first at up to one bit per cycle, stopping exactly at
// CHAIN_LENGTH bits. All outputs come straight from registers.
module config_chain_loader #(
  parameter int CHAIN_LENGTH = 1024,
  parameter int WORD_WIDTH   = 32,
  parameter int CLEAR_CYCLES = 4,
  parameter int CNT_WIDTH    = 16
) (
  input logic                  clock,
  input logic                  reset,
  config_chain_loader_if.slave bus
);

  localparam int REM_W = $clog2(WORD_WIDTH + 1);
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CHAIN_LEN_C = CNT_WIDTH'(CHAIN_LENGTH);
  localparam logic [REM_W-1:0]     WORD_LAST_C = REM_W'(WORD_WIDTH - 1);
  localparam logic [CLR_W-1:0]     CLR_LAST_C  = CLR_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

  state_t                state_reg;
  logic [WORD_WIDTH-1:0] shift_reg;     // bits of the current word not yet presented
  logic [REM_W-1:0]      rem_reg;       // how many of those remain
  logic [CLR_W-1:0]      clr_cnt_reg;
  logic                  word_ready_reg;
  logic                  out_reg;
  logic                  enable_reg;
  logic                  nreset_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic [CNT_WIDTH-1:0]  bits_reg;

  logic                  take;
  logic                  has_bits;
  logic                  shift_en;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic [REM_W-1:0]      rem_next;
  logic                  ready_next;

  // Shifter bookkeeping for the coming edge: a new word always refills the
  // shifter, otherwise drain one bit if any remain. word_ready is raised when
  // the shifter will be empty, unless the chain will be full.
  always_comb begin
    take       = bus.word_valid && word_ready_reg;
    has_bits   = (rem_reg != '0);
    shift_en   = take || has_bits;
    cnt_next   = bits_reg + CNT_WIDTH'(shift_en);
    rem_next   = take ? WORD_LAST_C : (has_bits ? rem_reg - 1'b1 : '0);
    ready_next = (rem_next == '0) && (cnt_next != CHAIN_LEN_C);
  end

  // Loader FSM with all outputs registered; abort beats everything while busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      rem_reg        <= '0;
      clr_cnt_reg    <= '0;
      word_ready_reg <= 1'b0;
      out_reg        <= 1'b0;
      enable_reg     <= 1'b0;
      nreset_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      bits_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          nreset_reg     <= 1'b1;
          enable_reg     <= 1'b0;
          busy_reg       <= 1'b0;
          word_ready_reg <= 1'b0;
          if (bus.start) begin
            state_reg   <= CLEAR;
            nreset_reg  <= 1'b0;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
            bits_reg    <= '0;
            clr_cnt_reg <= '0;
            rem_reg     <= '0;
          end
        end
        CLEAR: begin
          if (bus.abort) begin
            state_reg  <= IDLE;
            nreset_reg <= 1'b1;
            busy_reg   <= 1'b0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
            if (clr_cnt_reg == CLR_LAST_C) begin
              state_reg      <= LOAD;
              nreset_reg     <= 1'b1;
              word_ready_reg <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state_reg      <= IDLE;
            enable_reg     <= 1'b0;
            word_ready_reg <= 1'b0;
            busy_reg       <= 1'b0;
            rem_reg        <= '0;
          end else if (bits_reg == CHAIN_LEN_C) begin
            // Leftover high bits of the last word are simply dropped.
            state_reg      <= DONE;
            enable_reg     <= 1'b0;
            word_ready_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
            rem_reg        <= '0;
          end else begin
            if (take) begin
              out_reg   <= bus.word_data[0];
              shift_reg <= bus.word_data >> 1;
            end else if (has_bits) begin
              out_reg   <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
            enable_reg     <= shift_en;
            bits_reg       <= cnt_next;
            rem_reg        <= rem_next;
            word_ready_reg <= ready_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.word_ready          = word_ready_reg;
  assign bus.chain_config_out    = out_reg;
  assign bus.chain_config_enable = enable_reg;
  assign bus.chain_config_nreset = nreset_reg;
  assign bus.busy                = busy_reg;
  assign bus.done                = done_reg;
  assign bus.bits_loaded         = bits_reg;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: table of loads plus hand-written corner
// sequences; a bit scoreboard and a 40-bit model chain observe the serial side.
module tb_config_chain_loader;
  localparam int CL = 40;
  localparam int WW = 16;
  localparam int CC = 2;
  localparam int CW = 16;

  typedef struct {
    logic [47:0] words;      // word0 in [15:0], word1 in [31:16], word2 in [47:32]
    int          gap;        // starved cycles before word1
    logic [39:0] exp_chain;
    int          exp_run;    // longest run of enable=1
    bit          spur;       // pulse start during LOAD
  } vec_t;

  logic clk;
  logic rst;
  config_chain_loader_if #(.WORD_WIDTH(WW), .CNT_WIDTH(CW)) bus ();

  config_chain_loader #(
    .CHAIN_LENGTH(CL), .WORD_WIDTH(WW), .CLEAR_CYCLES(CC), .CNT_WIDTH(CW)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic sb[$];
  int pushed, hs_count, en_count, run_len, max_run, bubbles, nrst_low;
  logic [39:0] model_chain;
  logic last_out;
  vec_t vecs[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    model_chain = '0;
    last_out = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !bus.chain_config_nreset) model_chain = '0;
      if (!rst) begin
        if (!bus.chain_config_nreset) nrst_low++;
        if (bus.chain_config_enable) begin
          en_count++;
          run_len++;
          if (run_len > max_run) max_run = run_len;
          if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
          else check("chain_bit", 64'(bus.chain_config_out), 64'(sb.pop_front()));
          model_chain = {bus.chain_config_out, model_chain[39:1]};
          last_out = bus.chain_config_out;
        end else begin
          run_len = 0;
          if (bus.busy && bus.chain_config_nreset && bus.bits_loaded != 0 && bus.bits_loaded < CL) begin
            bubbles++;
            check("bubble_out_hold", 64'(bus.chain_config_out), 64'(last_out));
          end
        end
        if (bus.word_valid && bus.word_ready) begin
          hs_count++;
          $display("handshake word=0x%04h bits_loaded=%0d", bus.word_data, bus.bits_loaded);
          for (int i = 0; i < WW; i++) begin
            if (pushed < CL) begin
              sb.push_back(bus.word_data[i]);
              pushed++;
            end
          end
        end
      end
    end
  end

  task automatic clear_sb();
    sb.delete();
    pushed = 0; hs_count = 0; en_count = 0; run_len = 0;
    max_run = 0; bubbles = 0; nrst_low = 0;
  endtask

  task automatic do_start();
    clear_sb();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("start_busy", 64'(bus.busy), 64'd1);
    check("start_nreset", 64'(bus.chain_config_nreset), 64'd0);
    check("start_done", 64'(bus.done), 64'd0);
    check("start_bits", 64'(bus.bits_loaded), 64'd0);
  endtask

  // Called at posedge+1; word_ready is stable for the whole cycle then.
  task automatic send_word(input logic [15:0] w, input int hold);
    bit ok;
    int h;
    ok = 1'b0;
    h = hold;
    bus.word_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.word_ready) begin
        if (h > 0) h--;
        else begin
          bus.word_data = w;
          bus.word_valid = 1'b1;
          @(posedge clk); #1;
          bus.word_valid = 1'b0;
          ok = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
    end
    check("handshake_wait", 64'(ok), 64'd1);
  endtask

  task automatic wait_bits(input int n);
    for (int c = 0; c < 200; c++) begin
      if (bus.bits_loaded == CW'(n)) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_load(input vec_t v);
    do_start();
    send_word(v.words[15:0], 0);
    if (v.spur) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("spur_start_busy", 64'(bus.busy), 64'd1);
      check("spur_start_nreset", 64'(bus.chain_config_nreset), 64'd1);
    end
    send_word(v.words[31:16], v.gap);
    send_word(v.words[47:32], 0);
    for (int c = 0; c < 200; c++) begin
      if (bus.done) break;
      @(posedge clk); #1;
    end
    check("load_done", 64'(bus.done), 64'd1);
    check("load_busy", 64'(bus.busy), 64'd0);
    check("load_enable", 64'(bus.chain_config_enable), 64'd0);
    check("load_ready", 64'(bus.word_ready), 64'd0);
    check("load_bits", 64'(bus.bits_loaded), 64'(CL));
    check("load_chain", 64'(model_chain), 64'(v.exp_chain));
    check("load_handshakes", 64'(hs_count), 64'd3);
    check("load_enables", 64'(en_count), 64'(CL));
    check("load_bubbles", 64'(bubbles), 64'(v.gap));
    check("load_max_run", 64'(max_run), 64'(v.exp_run));
    check("load_nreset_low", 64'(nrst_low), 64'(CC));
    check("load_sb_empty", 64'(sb.size()), 64'd0);
    $display("load words=0x%012h gap=%0d chain=0x%010h", v.words, v.gap, model_chain);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{48'h1234_0FF0_A5C3, 0, 40'h34_0FF0_A5C3, 40, 1'b0};
    vecs[1] = '{48'h1234_0FF0_A5C3, 5, 40'h34_0FF0_A5C3, 24, 1'b0};
    vecs[2] = '{48'hABCD_0000_FFFF, 3, 40'hCD_0000_FFFF, 24, 1'b0};
    vecs[3] = '{48'h9F81_AAAA_5555, 0, 40'h81_AAAA_5555, 40, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.word_valid = 1'b0; bus.word_data = '0;
    clear_sb();
    #1;
    check("rst_ready", 64'(bus.word_ready), 64'd0);
    check("rst_out", 64'(bus.chain_config_out), 64'd0);
    check("rst_enable", 64'(bus.chain_config_enable), 64'd0);
    check("rst_nreset", 64'(bus.chain_config_nreset), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_bits", 64'(bus.bits_loaded), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_nreset", 64'(bus.chain_config_nreset), 64'd1);

    // Table: full rate, starvation, restart from DONE with stray start.
    for (int i = 0; i < 4; i++) run_load(vecs[i]);

    // In DONE: abort and word_valid are ignored.
    bus.abort = 1'b1; bus.word_valid = 1'b1; bus.word_data = 16'hBEEF;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(posedge clk); #1;
    bus.word_valid = 1'b0;
    check("done_abort_done", 64'(bus.done), 64'd1);
    check("done_ready", 64'(bus.word_ready), 64'd0);
    check("done_no_hs", 64'(hs_count), 64'd3);

    // Abort at bits_loaded=20, then reload.
    do_start();
    send_word(16'hA5C3, 0);
    send_word(16'h0FF0, 0);
    wait_bits(20);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_enable", 64'(bus.chain_config_enable), 64'd0);
    check("abort_nreset", 64'(bus.chain_config_nreset), 64'd1);
    check("abort_ready", 64'(bus.word_ready), 64'd0);
    check("abort_bits", 64'(bus.bits_loaded), 64'd20);
    run_load(vecs[0]);

    // Asynchronous reset mid-load at bit 10.
    do_start();
    send_word(16'hA5C3, 0);
    wait_bits(10);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 64'(bus.word_ready), 64'd0);
    check("arst_out", 64'(bus.chain_config_out), 64'd0);
    check("arst_enable", 64'(bus.chain_config_enable), 64'd0);
    check("arst_nreset", 64'(bus.chain_config_nreset), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_bits", 64'(bus.bits_loaded), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst_rel_nreset", 64'(bus.chain_config_nreset), 64'd0);
    @(posedge clk); #1;
    check("arst_edge_nreset", 64'(bus.chain_config_nreset), 64'd1);
    check("arst_edge_busy", 64'(bus.busy), 64'd0);

    // start+abort together: in IDLE start wins, in LOAD abort wins.
    clear_sb();
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    check("sa_idle_busy", 64'(bus.busy), 64'd1);
    check("sa_idle_nreset", 64'(bus.chain_config_nreset), 64'd0);
    send_word(16'h00FF, 0);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    check("sa_load_busy", 64'(bus.busy), 64'd0);
    check("sa_load_enable", 64'(bus.chain_config_enable), 64'd0);
    check("sa_load_done", 64'(bus.done), 64'd0);
    check("sa_load_nreset", 64'(bus.chain_config_nreset), 64'd1);
    check("sa_load_bits", 64'(bus.bits_loaded), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
